// File: rtl/cr_prefix_rec_do.sv
// cr_prefix_rec_do - output stage of the prefix recognition engine.
// Snapshots a 128-neuron result vector (LR0 or LR1) into a small buffer on a
// sequencer store pulse. It then serialises each snapshot into BUS_WIDTH-bit
// beats on a valid/ready egress bus.
// Optional build macro: CR_PREFIX_REC_DO_PARITY_EN adds per-byte even parity
// (rec_do_ob_par) registered alongside the beat data.
module cr_prefix_rec_do #(
    parameter int N_NEURONS    = 128,
    parameter int NEURON_WIDTH = 8,
    parameter int BUS_WIDTH    = 512,
    parameter int DEPTH        = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     rec_us_st,
    input  logic                                     rec_us_st_sel,
    input  logic                                     rec_us_st_last,
    input  logic [N_NEURONS-1:0][NEURON_WIDTH-1:0]   rec_di_lr0,
    input  logic [N_NEURONS-1:0][NEURON_WIDTH-1:0]   rec_di_lr1,
    output logic                                     rec_do_busy,
    output logic                                     rec_do_idle,
    output logic                                     rec_do_ovfl,
    output logic [BUS_WIDTH-1:0]                     rec_do_ob_data,
    output logic                                     rec_do_ob_valid,
    output logic                                     rec_do_ob_last,
    input  logic                                     rec_do_ob_ready
`ifdef CR_PREFIX_REC_DO_PARITY_EN
    ,
    output logic [BUS_WIDTH/8-1:0]                   rec_do_ob_par
`endif
);

    localparam int VEC_W   = N_NEURONS * NEURON_WIDTH;
    localparam int N_BEATS = VEC_W / BUS_WIDTH;
    localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    // Snapshot buffer; contents are don't-care after reset.
    logic [VEC_W-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0]     last_mem_q;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [BUS_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 ovfl_q, ovfl_d;

    logic                 busy;
    logic                 store_acc;
    logic                 pop;
    logic                 final_beat;
    logic [VEC_W-1:0]     st_vec;
    logic [PTR_W-1:0]     rd_next;
    logic [VEC_W-1:0]     cur_vec;
    logic                 cur_last;
    logic [VEC_W-1:0]     nxt_vec;
    logic                 nxt_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [BUS_WIDTH-1:0] beat_of(input logic [VEC_W-1:0] v,
                                                     input int unsigned     k);
        return v[k*BUS_WIDTH +: BUS_WIDTH];
    endfunction

    assign busy        = (count_q == CNT_W'(DEPTH));
    assign store_acc   = rec_us_st && !busy;
    assign st_vec      = rec_us_st_sel ? rec_di_lr1 : rec_di_lr0;
    assign final_beat  = (beat_cnt_q == BEAT_W'(N_BEATS - 1));
    assign pop         = (state_q == S_SEND) && rec_do_ob_ready && final_beat;
    assign rd_next     = ptr_inc(rd_ptr_q);
    assign cur_vec     = mem_q[rd_ptr_q];
    assign cur_last    = last_mem_q[rd_ptr_q];
    // A store landing in the same cycle as the final accept of the only
    // entry is not in mem_q yet, so take the next entry from the store path.
    assign nxt_vec     = (store_acc && (wr_ptr_q == rd_next)) ? st_vec : mem_q[rd_next];
    assign nxt_last    = (store_acc && (wr_ptr_q == rd_next)) ? rec_us_st_last : last_mem_q[rd_next];

    // Snapshot write port: capture the selected LR array and its frame-last flag.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            mem_q[wr_ptr_q]      <= st_vec;
            last_mem_q[wr_ptr_q] <= rec_us_st_last;
        end
    end

    // Next-state logic for pointers, occupancy, overflow and the egress FSM.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        beat_cnt_d = beat_cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        ovfl_d     = ovfl_q || (rec_us_st && busy);
        count_d    = count_q;

        if (store_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        case ({store_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (count_q != '0) begin
                    state_d    = S_SEND;
                    beat_cnt_d = '0;
                    data_d     = beat_of(cur_vec, 0);
                    valid_d    = 1'b1;
                    last_d     = (N_BEATS == 1) && cur_last;
                end
            end
            S_SEND: begin
                if (rec_do_ob_ready) begin
                    if (!final_beat) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        data_d     = beat_of(cur_vec, int'(beat_cnt_q) + 1);
                        last_d     = ((beat_cnt_q + 1'b1) == BEAT_W'(N_BEATS - 1)) && cur_last;
                    end else begin
                        rd_ptr_d = rd_next;
                        if ((count_q > CNT_W'(1)) || store_acc) begin
                            beat_cnt_d = '0;
                            data_d     = beat_of(nxt_vec, 0);
                            valid_d    = 1'b1;
                            last_d     = (N_BEATS == 1) && nxt_last;
                        end else begin
                            state_d    = S_IDLE;
                            beat_cnt_d = '0;
                            valid_d    = 1'b0;
                            last_d     = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // Control and egress output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            beat_cnt_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            ovfl_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            beat_cnt_q <= beat_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            ovfl_q     <= ovfl_d;
        end
    end

`ifdef CR_PREFIX_REC_DO_PARITY_EN
    logic [BUS_WIDTH/8-1:0] par_q, par_d;

    // Even parity per byte of the beat being loaded, so it tracks data_q exactly.
    always_comb begin
        par_d = '0;
        for (int unsigned b = 0; b < BUS_WIDTH / 8; b++) begin
            par_d[b] = ^data_d[8*b +: 8];
        end
    end

    // Parity register, updated on the same edges as the beat data.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= '0;
        end else begin
            par_q <= par_d;
        end
    end

    assign rec_do_ob_par = par_q;
`endif

    assign rec_do_busy     = busy;
    assign rec_do_idle     = (count_q == '0) && !valid_q;
    assign rec_do_ovfl     = ovfl_q;
    assign rec_do_ob_data  = data_q;
    assign rec_do_ob_valid = valid_q;
    assign rec_do_ob_last  = last_q;

endmodule

// File: tb/tb_cr_prefix_rec_do.sv
// Directed self-checking bench for cr_prefix_rec_do.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_cr_prefix_rec_do;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  st, st_sel, st_last;
    logic [127:0][7:0]     lr0, lr1;
    logic                  busy, idle, ovfl;
    logic [511:0]          ob_data;
    logic                  ob_valid, ob_last, ob_ready;
`ifdef CR_PREFIX_REC_DO_PARITY_EN
    logic [63:0]           ob_par;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    cr_prefix_rec_do #(
        .N_NEURONS   (128),
        .NEURON_WIDTH(8),
        .BUS_WIDTH   (512),
        .DEPTH       (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rec_us_st      (st),
        .rec_us_st_sel  (st_sel),
        .rec_us_st_last (st_last),
        .rec_di_lr0     (lr0),
        .rec_di_lr1     (lr1),
        .rec_do_busy    (busy),
        .rec_do_idle    (idle),
        .rec_do_ovfl    (ovfl),
        .rec_do_ob_data (ob_data),
        .rec_do_ob_valid(ob_valid),
        .rec_do_ob_last (ob_last),
        .rec_do_ob_ready(ob_ready)
`ifdef CR_PREFIX_REC_DO_PARITY_EN
        ,
        .rec_do_ob_par  (ob_par)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] ramp_beat(input int unsigned k);
        logic [511:0] r;
        for (int unsigned i = 0; i < 64; i++) r[8*i +: 8] = 8'(64*k + i);
        return r;
    endfunction

    function automatic logic [511:0] fill_beat(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic set_lr(input logic which, input logic [7:0] b);
        for (int unsigned i = 0; i < 128; i++) begin
            if (which) lr1[i] = b;
            else       lr0[i] = b;
        end
    endtask

    task automatic set_ramp_lr0();
        for (int unsigned i = 0; i < 128; i++) lr0[i] = 8'(i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; st = 1'b0; st_sel = 1'b0; st_last = 1'b0; ob_ready = 1'b0;
        lr0 = '0; lr1 = '0;
        do_reset();

        // Reset state
        chk("rst_valid", 512'(ob_valid), 512'(0));
        chk("rst_busy",  512'(busy),     512'(0));
        chk("rst_idle",  512'(idle),     512'(1));
        chk("rst_ovfl",  512'(ovfl),     512'(0));
        chk("rst_data",  ob_data,        512'(0));
        chk("rst_last",  512'(ob_last),  512'(0));
`ifdef CR_PREFIX_REC_DO_PARITY_EN
        chk("rst_par",   512'(ob_par),   512'(0));
`endif

        // Single store, ramp vector, ready high
        set_ramp_lr0(); st_sel = 1'b0; st_last = 1'b1; ob_ready = 1'b1; st = 1'b1;
        tick();
        st = 1'b0;
        chk("s1_t0_valid", 512'(ob_valid), 512'(0));
        chk("s1_t0_idle",  512'(idle),     512'(0));
        tick();
        chk("s1_b0_valid", 512'(ob_valid), 512'(1));
        chk("s1_b0_data",  ob_data,        ramp_beat(0));
        chk("s1_b0_last",  512'(ob_last),  512'(0));
        tick();
        chk("s1_b1_valid", 512'(ob_valid), 512'(1));
        chk("s1_b1_data",  ob_data,        ramp_beat(1));
        chk("s1_b1_last",  512'(ob_last),  512'(1));
        tick();
        chk("s1_end_valid", 512'(ob_valid), 512'(0));
        chk("s1_end_idle",  512'(idle),     512'(1));

        // Backpressure: hold for 5 cycles, vector not flagged last
        ob_ready = 1'b0; st_last = 1'b0; st = 1'b1;
        tick();
        st = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold_valid", 512'(ob_valid), 512'(1));
            chk("bp_hold_data",  ob_data,        ramp_beat(0));
            chk("bp_hold_last",  512'(ob_last),  512'(0));
            tick();
        end
        ob_ready = 1'b1;
        tick();
        chk("bp_b1_data",  ob_data,       ramp_beat(1));
        chk("bp_b1_last",  512'(ob_last), 512'(0));
        tick();
        chk("bp_end_valid", 512'(ob_valid), 512'(0));

        // Full buffer and overflow
        ob_ready = 1'b0;
        set_lr(1'b0, 8'h11); st_sel = 1'b0; st_last = 1'b0; st = 1'b1;
        tick();
        set_lr(1'b1, 8'h22); st_sel = 1'b1; st_last = 1'b1;
        tick();
        chk("ov_busy2", 512'(busy), 512'(1));
        chk("ov_ovfl2", 512'(ovfl), 512'(0));
        set_lr(1'b0, 8'h33); st_sel = 1'b0; st_last = 1'b0;
        tick();
        st = 1'b0;
        chk("ov_ovfl3",  512'(ovfl),     512'(1));
        chk("ov_busy3",  512'(busy),     512'(1));
        chk("ov_valid",  512'(ob_valid), 512'(1));
        chk("ov_a0",     ob_data,        fill_beat(8'h11));
        ob_ready = 1'b1;
        tick();
        chk("ov_a1",      ob_data,       fill_beat(8'h11));
        chk("ov_a1_last", 512'(ob_last), 512'(0));
        tick();
        chk("ov_b0",      ob_data,       fill_beat(8'h22));
        chk("ov_b0_vld",  512'(ob_valid), 512'(1));
        chk("ov_b0_last", 512'(ob_last), 512'(0));
        tick();
        chk("ov_b1",      ob_data,       fill_beat(8'h22));
        chk("ov_b1_last", 512'(ob_last), 512'(1));
        tick();
        chk("ov_end_valid", 512'(ob_valid), 512'(0));
        chk("ov_end_idle",  512'(idle),     512'(1));
        chk("ov_sticky",    512'(ovfl),     512'(1));

        // Same-cycle store and final-beat accept
        do_reset();
        ob_ready = 1'b1;
        set_lr(1'b0, 8'h44); st_sel = 1'b0; st_last = 1'b0; st = 1'b1;
        tick();
        st = 1'b0;
        tick();
        chk("sc_a0", ob_data, fill_beat(8'h44));
        tick();
        chk("sc_a1", ob_data, fill_beat(8'h44));
        set_lr(1'b1, 8'h55); st_sel = 1'b1; st_last = 1'b1; st = 1'b1;
        tick();
        st = 1'b0; ob_ready = 1'b0;
        chk("sc_b0",       ob_data,        fill_beat(8'h55));
        chk("sc_b0_valid", 512'(ob_valid), 512'(1));
        chk("sc_busy",     512'(busy),     512'(0));
        chk("sc_ovfl",     512'(ovfl),     512'(0));
        // One more store must fill the buffer, proving one entry was held
        set_lr(1'b0, 8'h66); st_sel = 1'b0; st_last = 1'b0; st = 1'b1;
        tick();
        st = 1'b0;
        chk("sc_busy_after", 512'(busy), 512'(1));
        ob_ready = 1'b1;
        tick();
        chk("sc_b1",      ob_data,       fill_beat(8'h55));
        chk("sc_b1_last", 512'(ob_last), 512'(1));
        tick();
        chk("sc_c0", ob_data, fill_beat(8'h66));
        tick();
        chk("sc_c1",      ob_data,       fill_beat(8'h66));
        chk("sc_c1_last", 512'(ob_last), 512'(0));
        tick();
        chk("sc_end_idle", 512'(idle), 512'(1));

        // Reset in the middle of a transfer
        set_ramp_lr0(); st_sel = 1'b0; st_last = 1'b1; ob_ready = 1'b0; st = 1'b1;
        tick();
        st = 1'b0;
        tick();
        ob_ready = 1'b1;
        tick();
        ob_ready = 1'b0;
        chk("mr_b1", ob_data, ramp_beat(1));
        st = 1'b1;
        tick();
        tick();
        st = 1'b0;
        chk("mr_pre_ovfl", 512'(ovfl), 512'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_valid", 512'(ob_valid), 512'(0));
        chk("mr_busy",  512'(busy),     512'(0));
        chk("mr_idle",  512'(idle),     512'(1));
        chk("mr_ovfl",  512'(ovfl),     512'(0));
        ob_ready = 1'b1; st = 1'b1;
        tick();
        st = 1'b0;
        tick();
        chk("mr_r0",      ob_data,       ramp_beat(0));
        chk("mr_r0_last", 512'(ob_last), 512'(0));
        tick();
        chk("mr_r1",      ob_data,       ramp_beat(1));
        chk("mr_r1_last", 512'(ob_last), 512'(1));
        tick();
        chk("mr_end_idle", 512'(idle), 512'(1));

`ifdef CR_PREFIX_REC_DO_PARITY_EN
        // Parity: 0x01 bytes -> odd count, parity bit 1; 0x03 -> 0
        set_lr(1'b1, 8'h01); st_sel = 1'b1; st = 1'b1;
        tick();
        st = 1'b0;
        tick();
        chk("par01_b0", 512'(ob_par), 512'({64{1'b1}}));
        tick();
        chk("par01_b1", 512'(ob_par), 512'({64{1'b1}}));
        tick();
        set_lr(1'b1, 8'h03); st = 1'b1;
        tick();
        st = 1'b0;
        tick();
        chk("par03_b0", 512'(ob_par), 512'(0));
        tick();
        chk("par03_b1", 512'(ob_par), 512'(0));
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
